// File: rtl/store_buffer.sv
// Store buffer: in-order circular queue from dispatch through LSU fill and ROB commit to D-cache drain.
// Optional combinational store-to-load forwarding is enabled with the SB_FWD_EN macro.
module store_buffer #(
    parameter int unsigned SB_DEPTH       = 16,
    parameter int unsigned DISPATCH_WIDTH = 4,
    parameter int unsigned COMMIT_WIDTH   = 2,
    parameter int unsigned PLEN           = 32,
    parameter int unsigned XLEN           = 32,
    localparam int unsigned SB_IDX_WIDTH  = $clog2(SB_DEPTH)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic [DISPATCH_WIDTH-1:0]                   alloc_req_i,
    output logic                                        alloc_ready_o,
    output logic [DISPATCH_WIDTH-1:0][SB_IDX_WIDTH-1:0] alloc_id_o,
    input  logic                                        exe_valid_i,
    input  logic [SB_IDX_WIDTH-1:0]                     exe_sb_id_i,
    input  logic [PLEN-1:0]                             exe_addr_i,
    input  logic [XLEN-1:0]                             exe_data_i,
    input  logic [XLEN/8-1:0]                           exe_be_i,
    input  logic [COMMIT_WIDTH-1:0]                     commit_is_store_i,
    input  logic [COMMIT_WIDTH-1:0][SB_IDX_WIDTH-1:0]   commit_sb_id_i,
    input  logic                                        flush_i,
    output logic                                        dc_req_valid_o,
    output logic [PLEN-1:0]                             dc_req_addr_o,
    output logic [XLEN-1:0]                             dc_req_data_o,
    output logic [XLEN/8-1:0]                           dc_req_be_o,
    input  logic                                        dc_req_ready_i,
    output logic                                        sb_empty_o,
    output logic [SB_IDX_WIDTH:0]                       sb_count_o
`ifdef SB_FWD_EN
    ,
    input  logic                                        ld_valid_i,
    input  logic [PLEN-1:0]                             ld_addr_i,
    input  logic [SB_IDX_WIDTH:0]                       ld_tail_i,
    output logic                                        fwd_hit_o,
    output logic [XLEN-1:0]                             fwd_data_o
`endif
);

    typedef logic [SB_IDX_WIDTH:0]   ptr_t;
    typedef logic [SB_IDX_WIDTH-1:0] idx_t;

    ptr_t head_q, head_d;
    ptr_t commit_q, commit_d;
    ptr_t tail_q, tail_d;
    logic [SB_DEPTH-1:0] valid_q, valid_d;
    logic [SB_DEPTH-1:0] exec_q, exec_d;
    logic [SB_DEPTH-1:0] cmt_q, cmt_d;

    logic [PLEN-1:0]   addr_mem [SB_DEPTH];
    logic [XLEN-1:0]   data_mem [SB_DEPTH];
    logic [XLEN/8-1:0] be_mem   [SB_DEPTH];

    ptr_t count;
    ptr_t free_cnt;
    idx_t head_idx;
    logic dc_fire;
    logic exe_wr;
    ptr_t alloc_ofs [DISPATCH_WIDTH+1];
    ptr_t alloc_pos [DISPATCH_WIDTH];

    assign count         = tail_q - head_q;
    assign free_cnt      = ptr_t'(SB_DEPTH) - count;
    assign alloc_ready_o = free_cnt >= ptr_t'(DISPATCH_WIDTH);
    assign sb_count_o    = count;
    assign sb_empty_o    = (count == '0);
    assign head_idx      = head_q[SB_IDX_WIDTH-1:0];

    // Lane ids are compacted: each requesting lane takes the next free slot after the lanes below it.
    assign alloc_ofs[0] = '0;
    generate
        for (genvar gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_alloc
            assign alloc_ofs[gi+1] = alloc_ofs[gi] + ptr_t'(alloc_req_i[gi]);
            assign alloc_pos[gi]   = tail_q + alloc_ofs[gi];
            assign alloc_id_o[gi]  = alloc_pos[gi][SB_IDX_WIDTH-1:0];
        end
    endgenerate

    // Drain request is a pure function of registered state, so it cannot glitch on inputs.
    assign dc_req_valid_o = valid_q[head_idx] & exec_q[head_idx] & cmt_q[head_idx];
    assign dc_req_addr_o  = dc_req_valid_o ? addr_mem[head_idx] : '0;
    assign dc_req_data_o  = dc_req_valid_o ? data_mem[head_idx] : '0;
    assign dc_req_be_o    = dc_req_valid_o ? be_mem[head_idx]   : '0;
    assign dc_fire        = dc_req_valid_o & dc_req_ready_i;
    assign exe_wr         = exe_valid_i & valid_q[exe_sb_id_i];

    always_comb begin
        head_d   = head_q;
        commit_d = commit_q;
        tail_d   = tail_q;
        valid_d  = valid_q;
        exec_d   = exec_q;
        cmt_d    = cmt_q;

        if (dc_fire) begin
            valid_d[head_idx] = 1'b0;
            exec_d[head_idx]  = 1'b0;
            cmt_d[head_idx]   = 1'b0;
            head_d            = head_q + ptr_t'(1);
        end

        if (exe_wr) begin
            exec_d[exe_sb_id_i] = 1'b1;
        end

        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (commit_is_store_i[j]) begin
                cmt_d[commit_sb_id_i[j]] = 1'b1;
                commit_d                 = commit_d + ptr_t'(1);
            end
        end

        // Flush rolls the tail back to the post-commit pointer; committed stores keep draining.
        if (flush_i) begin
            tail_d = commit_d;
            for (int k = 0; k < SB_DEPTH; k++) begin
                if (!cmt_d[k]) begin
                    valid_d[k] = 1'b0;
                    exec_d[k]  = 1'b0;
                end
            end
        end else if (alloc_ready_o) begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                if (alloc_req_i[i]) begin
                    valid_d[alloc_id_o[i]] = 1'b1;
                    exec_d[alloc_id_o[i]]  = 1'b0;
                    cmt_d[alloc_id_o[i]]   = 1'b0;
                end
            end
            tail_d = tail_q + alloc_ofs[DISPATCH_WIDTH];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= '0;
            valid_q  <= '0;
            exec_q   <= '0;
            cmt_q    <= '0;
        end else begin
            head_q   <= head_d;
            commit_q <= commit_d;
            tail_q   <= tail_d;
            valid_q  <= valid_d;
            exec_q   <= exec_d;
            cmt_q    <= cmt_d;
        end
    end

    // Payload needs no reset: it is only observed once the entry's EXEC flag is set.
    always_ff @(posedge clk_i) begin
        if (exe_wr) begin
            addr_mem[exe_sb_id_i] <= exe_addr_i;
            data_mem[exe_sb_id_i] <= exe_data_i;
            be_mem[exe_sb_id_i]   <= exe_be_i;
        end
    end

`ifdef SB_FWD_EN
    localparam int unsigned WORD_LSB = $clog2(XLEN/8);

    ptr_t fwd_span;
    ptr_t fwd_pos;
    idx_t fwd_idx;
    logic unused_ld_offset;

    assign fwd_span         = ld_tail_i - head_q;
    assign unused_ld_offset = ^ld_addr_i[WORD_LSB-1:0];

    // Walk oldest to youngest so the last match left standing is the youngest older store.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fwd_pos    = '0;
        fwd_idx    = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            fwd_pos = head_q + ptr_t'(k);
            fwd_idx = fwd_pos[SB_IDX_WIDTH-1:0];
            if (ld_valid_i && (ptr_t'(k) < fwd_span) && valid_q[fwd_idx] && exec_q[fwd_idx]
                && (addr_mem[fwd_idx][PLEN-1:WORD_LSB] == ld_addr_i[PLEN-1:WORD_LSB])
                && (&be_mem[fwd_idx])) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_mem[fwd_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: scoreboard of committed stores compared against D-cache drains.
module tb_store_buffer;
    localparam int DEPTH = 16;
    localparam int DW    = 4;
    localparam int CW    = 2;
    localparam int PLEN  = 32;
    localparam int XLEN  = 32;
    localparam int IW    = 4;

    typedef struct packed {
        logic [PLEN-1:0]   addr;
        logic [XLEN-1:0]   data;
        logic [XLEN/8-1:0] be;
    } st_t;

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0]          alloc_req;
    logic                   alloc_ready;
    logic [DW-1:0][IW-1:0]  alloc_id;
    logic                   exe_valid;
    logic [IW-1:0]          exe_id;
    logic [PLEN-1:0]        exe_addr;
    logic [XLEN-1:0]        exe_data;
    logic [XLEN/8-1:0]      exe_be;
    logic [CW-1:0]          cmt_is_store;
    logic [CW-1:0][IW-1:0]  cmt_id;
    logic                   flush;
    logic                   dc_valid;
    logic [PLEN-1:0]        dc_addr;
    logic [XLEN-1:0]        dc_data;
    logic [XLEN/8-1:0]      dc_be;
    logic                   dc_ready;
    logic                   sb_empty;
    logic [IW:0]            sb_count;
`ifdef SB_FWD_EN
    logic                   ld_valid;
    logic [PLEN-1:0]        ld_addr;
    logic [IW:0]            ld_tail;
    logic                   fwd_hit;
    logic [XLEN-1:0]        fwd_data;
`endif

    st_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    bit  rand_ready = 1'b0;

    always #5 clk = ~clk;

    store_buffer #(
        .SB_DEPTH(DEPTH), .DISPATCH_WIDTH(DW), .COMMIT_WIDTH(CW), .PLEN(PLEN), .XLEN(XLEN)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .alloc_req_i(alloc_req), .alloc_ready_o(alloc_ready), .alloc_id_o(alloc_id),
        .exe_valid_i(exe_valid), .exe_sb_id_i(exe_id), .exe_addr_i(exe_addr),
        .exe_data_i(exe_data), .exe_be_i(exe_be),
        .commit_is_store_i(cmt_is_store), .commit_sb_id_i(cmt_id), .flush_i(flush),
        .dc_req_valid_o(dc_valid), .dc_req_addr_o(dc_addr), .dc_req_data_o(dc_data),
        .dc_req_be_o(dc_be), .dc_req_ready_i(dc_ready),
        .sb_empty_o(sb_empty), .sb_count_o(sb_count)
`ifdef SB_FWD_EN
        ,
        .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_tail_i(ld_tail),
        .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data)
`endif
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every accepted drain must match the oldest outstanding committed store.
    always @(negedge clk) begin : drain_mon
        st_t e;
        if (!rst && dc_valid && dc_ready) begin
            check("drain_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("drain_payload", {dc_addr, dc_data, dc_be}, e);
                $display("drain addr=0x%08h data=0x%08h be=0x%0h", dc_addr, dc_data, dc_be);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) dc_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_alloc(input logic [DW-1:0] req, input int first);
        int n;
        n = 0;
        alloc_req = req;
        #1;
        for (int i = 0; i < DW; i++) begin
            if (req[i]) begin
                check($sformatf("alloc_id_lane%0d", i), alloc_id[i], (first + n) % DEPTH);
                n++;
            end
        end
        tick();
        alloc_req = '0;
    endtask

    task automatic do_exe(input int id, input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                          input logic [XLEN/8-1:0] b);
        exe_valid = 1'b1;
        exe_id    = IW'(id % DEPTH);
        exe_addr  = a;
        exe_data  = d;
        exe_be    = b;
        tick();
        exe_valid = 1'b0;
    endtask

    task automatic do_commit(input int n, input int id0);
        for (int j = 0; j < CW; j++) begin
            cmt_is_store[j] = (j < n);
            cmt_id[j]       = IW'((id0 + j) % DEPTH);
        end
        tick();
        cmt_is_store = '0;
    endtask

    task automatic wait_empty(input int budget);
        int w;
        w = 0;
        while (sb_count != 0 && w < budget) begin
            tick();
            w++;
        end
        check("drain_done_count", sb_count, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int t;
        int n;
        int w;
        rst = 1'b1;
        alloc_req = '0; exe_valid = 1'b0; exe_id = '0; exe_addr = '0; exe_data = '0; exe_be = '0;
        cmt_is_store = '0; cmt_id = '0; flush = 1'b0; dc_ready = 1'b0;
`ifdef SB_FWD_EN
        ld_valid = 1'b0; ld_addr = '0; ld_tail = '0;
`endif
        tick();
        tick();
        check("rst_dc_valid", dc_valid, 0);
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_empty", sb_empty, 1);
        check("rst_count", sb_count, 0);
        check("rst_payload", {dc_addr, dc_data, dc_be}, 0);
        rst = 1'b0;
        tick();
        alloc_req = 4'b1010;
        #1;
        check("compact_lane1", alloc_id[1], 0);
        check("compact_lane3", alloc_id[3], 1);
        alloc_req = '0;

        // Fill to full, try one more group, then flush everything uncommitted away.
        for (int g = 0; g < 3; g++) do_alloc(4'hF, 4 * g);
        check("fill_count12", sb_count, 12);
        check("fill_ready12", alloc_ready, 1);
        do_alloc(4'hF, 12);
        check("full_count", sb_count, 16);
        check("full_ready", alloc_ready, 0);
        alloc_req = 4'hF;
        tick();
        alloc_req = '0;
        check("full_no_alloc", sb_count, 16);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_all_count", sb_count, 0);
        check("flush_all_empty", sb_empty, 1);

        // Drain stall: payload holds while the cache back-pressures.
        do_alloc(4'h1, 0);
        do_exe(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        check("precommit_valid", dc_valid, 0);
        exp_q.push_back('{32'h8000_0010, 32'hDEAD_BEEF, 4'hF});
        do_commit(1, 0);
        for (int c = 0; c < 3; c++) begin
            check("stall_valid", dc_valid, 1);
            check("stall_payload", {dc_addr, dc_data, dc_be}, {32'h8000_0010, 32'hDEAD_BEEF, 4'hF});
            tick();
        end
        dc_ready = 1'b1;
        tick();
        dc_ready = 1'b0;
        check("stall_count_after", sb_count, 0);
        alloc_req = 4'h1;
        #1;
        check("head_advanced_id", alloc_id[0], 1);
        alloc_req = '0;

        // Reset while a drain request is pending.
        do_alloc(4'h1, 1);
        do_exe(1, 32'h40, 32'h1234_5678, 4'hF);
        do_commit(1, 1);
        check("rmd_valid_before", dc_valid, 1);
        rst = 1'b1;
        #1;
        check("rmd_valid", dc_valid, 0);
        check("rmd_count", sb_count, 0);
        check("rmd_alloc_ready", alloc_ready, 1);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();

        // Flush with a same-cycle commit.
        do_alloc(4'hF, 0);
        do_alloc(4'h3, 4);
        for (int i = 0; i < 6; i++) do_exe(i, 32'h1000 + 4 * i, 32'h100 + i, 4'hF);
        exp_q.push_back('{32'h1000, 32'h100, 4'hF});
        exp_q.push_back('{32'h1004, 32'h101, 4'hF});
        do_commit(2, 0);
        exp_q.push_back('{32'h1008, 32'h102, 4'hF});
        flush = 1'b1;
        do_commit(1, 2);
        flush = 1'b0;
        check("flush_count", sb_count, 3);
        alloc_req = 4'h1;
        #1;
        check("flush_tail_id", alloc_id[0], 3);
        alloc_req = '0;
        do_exe(3, 32'h2222, 32'hBAD, 4'hF);
        dc_ready = 1'b1;
        wait_empty(50);
        check("flush_drained_empty", sb_empty, 1);
        dc_ready = 1'b0;

        // Commit without EXEC waits; the earlier fill to a FREE slot must not count.
        do_alloc(4'h1, 3);
        do_commit(1, 3);
        tick();
        tick();
        check("no_exec_valid", dc_valid, 0);
        exp_q.push_back('{32'h3330, 32'h333, 4'hF});
        do_exe(3, 32'h3330, 32'h333, 4'hF);
        dc_ready = 1'b1;
        wait_empty(20);

        // Wrap: 40 stores in groups of four with random back-pressure.
        t = 4;
        n = 0;
        rand_ready = 1'b1;
        for (int g = 0; g < 10; g++) begin
            w = 0;
            while (!alloc_ready && w < 200) begin
                tick();
                w++;
            end
            check("wrap_alloc_wait", alloc_ready, 1);
            do_alloc(4'hF, t);
            for (int i = 0; i < 4; i++) do_exe(t + i, 32'h8000 + 4 * (n + i), XLEN'(n + i), 4'hF);
            for (int i = 0; i < 4; i++) exp_q.push_back('{32'h8000 + 4 * (n + i), XLEN'(n + i), 4'hF});
            do_commit(2, t);
            do_commit(2, t + 2);
            t += 4;
            n += 4;
        end
        rand_ready = 1'b0;
        dc_ready = 1'b1;
        wait_empty(200);
        check("wrap_empty", sb_empty, 1);
        check("wrap_sb_left", exp_q.size(), 0);
        dc_ready = 1'b0;

`ifdef SB_FWD_EN
        pulse_reset();
        do_alloc(4'hF, 0);
        do_alloc(4'hF, 4);
        do_exe(3, 32'h100, 32'h11, 4'hF);
        do_exe(5, 32'h100, 32'h55, 4'hF);
        ld_valid = 1'b1;
        ld_addr  = 32'h100;
        ld_tail  = 5'd6;
        #1;
        check("fwd_hit_t6", fwd_hit, 1);
        check("fwd_data_t6", fwd_data, 32'h55);
        ld_tail = 5'd4;
        #1;
        check("fwd_hit_t4", fwd_hit, 1);
        check("fwd_data_t4", fwd_data, 32'h11);
        ld_tail = 5'd3;
        #1;
        check("fwd_miss_t3", fwd_hit, 0);
        check("fwd_miss_data", fwd_data, 0);
        ld_valid = 1'b0;
        pulse_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
